// File: rtl/audio_proc_pkg.sv
// rtl/audio_proc_pkg.sv - shared widths and scanner FSM encoding for the audio FFT back end
package audio_proc_pkg;

    localparam int FFT_ADDR_W = 10;
    localparam int FFT_PWR_W  = 16;
    localparam int FFT_EXP_W  = 6;
    localparam int ENERGY_W   = 25;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_SCAN    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } scan_state_t;

endpackage

// File: rtl/fft_rd_delay.sv
// rtl/fft_rd_delay.sv - RD_LAT-deep shift register carrying {valid, addr} alongside the FFT read
module fft_rd_delay #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {valid_i, addr_i};
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {valid_o, addr_o} = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_peak_scanner.sv
// rtl/fft_peak_scanner.sv - triggers one FFT frame, sweeps bins, reports peak/energy/exponent
// Optional threshold detector (thresh / voice_active) enabled by FFT_PEAK_THRESH_EN.
module fft_peak_scanner
    import audio_proc_pkg::*;
#(
    parameter int NUM_BINS    = 512,
    parameter int FIRST_BIN   = 1,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scan_req,
    output logic                  busy,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic [FFT_ADDR_W-1:0] fft_addr,
    input  logic [FFT_PWR_W-1:0]  fft_power,
    input  logic [FFT_EXP_W-1:0]  fft_exp,
    output logic [FFT_ADDR_W-1:0] peak_bin,
    output logic [FFT_PWR_W-1:0]  peak_power,
    output logic [ENERGY_W-1:0]   energy,
    output logic [FFT_EXP_W-1:0]  frame_exp,
    output logic                  result_valid,
`ifdef FFT_PEAK_THRESH_EN
    input  logic [FFT_PWR_W-1:0]  thresh,
    output logic                  voice_active,
`endif
    output logic                  err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + RD_LAT + 1);
    localparam logic [FFT_ADDR_W-1:0] ADDR_FIRST = FFT_ADDR_W'(FIRST_BIN);
    localparam logic [FFT_ADDR_W-1:0] ADDR_LAST  = FFT_ADDR_W'(NUM_BINS - 1);

    scan_state_t state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [FFT_ADDR_W-1:0] addr_q;
    logic                  dly_valid;
    logic [FFT_ADDR_W-1:0] dly_addr;
    logic [FFT_PWR_W-1:0]  acc_pwr_q;
    logic [FFT_ADDR_W-1:0] acc_bin_q;
    logic [ENERGY_W-1:0]   acc_energy_q;
    logic                  first_q;
    logic [FFT_ADDR_W-1:0] peak_bin_q;
    logic [FFT_PWR_W-1:0]  peak_power_q;
    logic [ENERGY_W-1:0]   energy_q;
    logic [FFT_EXP_W-1:0]  frame_exp_q;
    logic                  result_valid_q;
    logic                  err_q;
    logic                  wait_expired;
    logic                  timeout_hit;

    // One budget covers both done phases, so a core that never toggles done cannot hang us.
    assign wait_expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_hit  = wait_expired &&
                          (((state_q == ST_WAIT_LO) && fft_done) ||
                           ((state_q == ST_WAIT_HI) && !fft_done));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (scan_req) state_d = ST_ARM;
            ST_ARM:     state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!fft_done) state_d = ST_WAIT_HI;
                        else if (timeout_hit) state_d = ST_IDLE;
            ST_WAIT_HI: if (fft_done) state_d = ST_SCAN;
                        else if (timeout_hit) state_d = ST_IDLE;
            ST_SCAN:    if (addr_q == ADDR_LAST) state_d = ST_DRAIN;
            ST_DRAIN:   if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fft_start = (state_q == ST_ARM);
        busy      = (state_q != ST_IDLE);
    end

    fft_rd_delay #(
        .DEPTH  (RD_LAT),
        .ADDR_W (FFT_ADDR_W)
    ) u_rd_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (state_q == ST_SCAN),
        .addr_i  (addr_q),
        .valid_o (dly_valid),
        .addr_o  (dly_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            if ((state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI) || (state_q == ST_DRAIN)) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            if ((state_q == ST_WAIT_HI) && fft_done) begin
                addr_q <= ADDR_FIRST;
            end else if ((state_q == ST_SCAN) && (addr_q != ADDR_LAST)) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_pwr_q    <= '0;
            acc_bin_q    <= '0;
            acc_energy_q <= '0;
            first_q      <= 1'b0;
        end else if ((state_q == ST_IDLE) && scan_req) begin
            acc_pwr_q    <= '0;
            acc_bin_q    <= '0;
            acc_energy_q <= '0;
            first_q      <= 1'b1;
        end else if (dly_valid) begin
            acc_energy_q <= acc_energy_q + {{(ENERGY_W - FFT_PWR_W){1'b0}}, fft_power};
            // Strict compare over ascending bins keeps the lowest bin on ties.
            if (first_q || (fft_power > acc_pwr_q)) begin
                acc_pwr_q <= fft_power;
                acc_bin_q <= dly_addr;
            end
            first_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_bin_q     <= '0;
            peak_power_q   <= '0;
            energy_q       <= '0;
            frame_exp_q    <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            result_valid_q <= (state_q == ST_DONE);
            if ((state_q == ST_IDLE) && scan_req) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if ((state_q == ST_WAIT_HI) && fft_done) begin
                frame_exp_q <= fft_exp;
            end
            if (state_q == ST_DONE) begin
                peak_bin_q   <= acc_bin_q;
                peak_power_q <= acc_pwr_q;
                energy_q     <= acc_energy_q;
            end
        end
    end

`ifdef FFT_PEAK_THRESH_EN
    logic voice_active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            voice_active_q <= 1'b0;
        end else if (timeout_hit) begin
            voice_active_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            voice_active_q <= (acc_pwr_q >= thresh);
        end
    end

    assign voice_active = voice_active_q;
`endif

    assign fft_addr     = addr_q;
    assign peak_bin     = peak_bin_q;
    assign peak_power   = peak_power_q;
    assign energy       = energy_q;
    assign frame_exp    = frame_exp_q;
    assign result_valid = result_valid_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_fft_peak_scanner.sv
// tb/tb_fft_peak_scanner.sv - scoreboard bench for fft_peak_scanner with an FFT core model
module tb_fft_peak_scanner;

    localparam int NB = 512;
    localparam int FB = 1;
    localparam int RL = 2;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scan_req = 1'b0;
    logic        fft_done = 1'b0;
    logic [15:0] fft_power = '0;
    logic [5:0]  fft_exp = '0;
    logic        busy, fft_start, result_valid, err_timeout;
    logic [9:0]  fft_addr, peak_bin;
    logic [15:0] peak_power;
    logic [24:0] energy;
    logic [5:0]  frame_exp;
    logic [15:0] th_val = 16'h1000;
`ifdef FFT_PEAK_THRESH_EN
    logic        voice_active;
`endif

    fft_peak_scanner #(
        .NUM_BINS    (NB),
        .FIRST_BIN   (FB),
        .RD_LAT      (RL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .scan_req     (scan_req),
        .busy         (busy),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .fft_addr     (fft_addr),
        .fft_power    (fft_power),
        .fft_exp      (fft_exp),
        .peak_bin     (peak_bin),
        .peak_power   (peak_power),
        .energy       (energy),
        .frame_exp    (frame_exp),
        .result_valid (result_valid),
`ifdef FFT_PEAK_THRESH_EN
        .thresh       (th_val),
        .voice_active (voice_active),
`endif
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FFT core bin memory with a two-cycle registered read
    logic [15:0] mem [NB];
    logic [15:0] rd_p1 = '0;
    always @(posedge clk) begin
        rd_p1     <= mem[fft_addr];
        fft_power <= rd_p1;
    end

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] pwr;
        logic [24:0] en;
        logic [5:0]  ex;
        logic        va;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int n_start = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: lowest-index maximum and plain sum over the scanned bins
    task automatic push_expect();
        exp_t   e;
        int     best;
        longint sum;
        logic [15:0] mx;
        best = -1;
        sum = 0;
        mx = '0;
        for (int b = FB; b < NB; b++) begin
            sum += mem[b];
            if (best < 0 || mem[b] > mx) begin
                mx = mem[b];
                best = b;
            end
        end
        e.bin = 10'(best);
        e.pwr = mx;
        e.en  = 25'(sum);
        e.ex  = fft_exp;
        e.va  = (mx >= th_val);
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (fft_start) n_start++;
        if (reset_n && result_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("peak_bin", peak_bin, mon_e.bin);
                chk("peak_power", peak_power, mon_e.pwr);
                chk("energy", energy, mon_e.en);
                chk("frame_exp", frame_exp, mon_e.ex);
`ifdef FFT_PEAK_THRESH_EN
                chk("voice_active", voice_active, mon_e.va);
`endif
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fft_start"}, fft_start, 0);
        chk({tag, "_fft_addr"}, fft_addr, 0);
        chk({tag, "_peak_bin"}, peak_bin, 0);
        chk({tag, "_peak_power"}, peak_power, 0);
        chk({tag, "_energy"}, energy, 0);
        chk({tag, "_frame_exp"}, frame_exp, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
`ifdef FFT_PEAK_THRESH_EN
        chk({tag, "_voice_active"}, voice_active, 0);
`endif
    endtask

    task automatic run_frame(input bit stale, input int lo_dly, input int hi_dly, input bit extra_req);
        int s0, t_done, waitc;
        fft_done = stale;
        push_expect();
        s0 = n_start;
        scan_req = 1'b1;
        cycles(1);
        scan_req = 1'b0;
        chk("busy_after_req", busy, 1);
        chk("err_cleared_by_req", err_timeout, 0);
        if (stale) begin
            cycles(lo_dly);
            fft_done = 1'b0;
        end
        cycles(hi_dly);
        fft_done = 1'b1;
        t_done = cyc;
        if (extra_req) begin
            cycles(50);
            scan_req = 1'b1;
            cycles(1);
            scan_req = 1'b0;
        end
        waitc = 0;
        @(negedge clk);
        while (!result_valid && waitc < 3000) begin
            @(negedge clk);
            waitc++;
        end
        if (!result_valid) begin
            chk("result_valid_timeout", 0, 1);
        end else begin
            chk("done_to_result_latency", cyc - t_done, RL + (NB - FB) + 2);
            chk("busy_drops_with_result", busy, 0);
        end
        chk("fft_start_pulses", n_start - s0, 1);
        cycles(3);
        chk("idle_after_frame", busy, 0);
    endtask

    task automatic rand_mem(input int maxv);
        for (int b = 0; b < NB; b++) mem[b] = 16'($urandom_range(0, maxv));
    endtask

    int t_a, lat;

    initial begin
        for (int b = 0; b < NB; b++) mem[b] = '0;
        reset_n = 1'b0;
        cycles(3);
        chk_zero("reset");
        reset_n = 1'b1;
        cycles(2);

        for (int b = 0; b < NB; b++) mem[b] = 16'(b * 3);
        mem[37] = 16'hF000;
        fft_exp = 6'd5;
        run_frame(1'b0, 1, 10, 1'b0);
        chk("ramp_peak_bin", peak_bin, 37);
        chk("ramp_peak_power", peak_power, 16'hF000);
        chk("ramp_frame_exp", frame_exp, 5);

        rand_mem(16'h7FFF);
        mem[10] = 16'h8000;
        mem[200] = 16'h8000;
        fft_exp = 6'($urandom);
        run_frame(1'b0, 1, 5, 1'b0);
        chk("tie_peak_bin", peak_bin, 10);

        rand_mem(16'hFFFF);
        fft_exp = 6'($urandom);
        run_frame(1'b1, 5, 100, 1'b0);

        for (int b = 0; b < NB; b++) mem[b] = 16'hFFFF;
        fft_exp = 6'd63;
        run_frame(1'b1, 2, 4, 1'b1);
        chk("full_scale_energy", energy, 25'h1FEFE01);

        fft_done = 1'b0;
        scan_req = 1'b1;
        cycles(1);
        scan_req = 1'b0;
        t_a = cyc;
        lat = 0;
        @(negedge clk);
        while (!err_timeout && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("timeout_err_set", err_timeout, 1);
        chk("timeout_window", ((cyc - t_a) >= TO) && ((cyc - t_a) <= TO + 2), 1);
        chk("timeout_busy_low", busy, 0);
`ifdef FFT_PEAK_THRESH_EN
        chk("timeout_voice_clear", voice_active, 0);
`endif
        cycles(20);
        chk("timeout_err_sticky", err_timeout, 1);

        for (int k = 0; k < 4; k++) begin
            rand_mem(16'hFFFF);
            fft_exp = 6'($urandom);
            run_frame(1'($urandom), $urandom_range(1, 8), $urandom_range(3, 40), 1'($urandom));
        end

        rand_mem(16'h0FFE);
        mem[$urandom_range(FB, NB - 1)] = 16'h0FFF;
        th_val = 16'h1000;
        run_frame(1'b0, 1, 6, 1'b0);
`ifdef FFT_PEAK_THRESH_EN
        chk("below_thresh_voice", voice_active, 0);
`endif
        chk("below_thresh_peak", peak_power, 16'h0FFF);

        rand_mem(16'hFFFF);
        fft_done = 1'b0;
        scan_req = 1'b1;
        cycles(1);
        scan_req = 1'b0;
        cycles(4);
        fft_done = 1'b1;
        cycles(200);
        reset_n = 1'b0;
        #1;
        chk_zero("midscan_reset");
        cycles(2);
        reset_n = 1'b1;
        cycles(600);
        chk("post_reset_idle", busy, 0);

        rand_mem(16'hFFFF);
        fft_exp = 6'($urandom);
        run_frame(1'b1, 3, 7, 1'b0);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
